// File: rtl/pattern_scan_ctrl_if.sv
// Config, serial-lane and status bundle for pattern_scan_ctrl.
// The master drives configuration and data; the slave (the scanner) drives status.
interface pattern_scan_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_target, cfg_overlap, abort, in_valid, in_bit,
        input  cfg_ready, match, match_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_target, cfg_overlap, abort, in_valid, in_bit,
        output cfg_ready, match, match_cnt, busy, done
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern scanner: matches a stored PAT_W-bit pattern on a gated
// bit stream, counts occurrences and signals completion when a target count is reached.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    pattern_scan_ctrl_if.slave  bus
);
    localparam int              FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [PAT_W-1:0]   hist_r, hist_nxt_s;
    logic [FILL_W-1:0]  fill_r, fill_nxt_s;
    logic [PAT_W-1:0]   pat_r, pat_nxt_s;
    logic [CNT_W-1:0]   tgt_r, tgt_nxt_s;
    logic               ovl_r, ovl_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               match_r, match_nxt_s;
    logic               busy_r, done_r, ready_r;

    logic [PAT_W-1:0]   shift_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               hit_s;

    // State register and registered status outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= FILL_ZERO;
            pat_r   <= {PAT_W{1'b0}};
            tgt_r   <= CNT_ZERO;
            ovl_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
            match_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
            pat_r   <= pat_nxt_s;
            tgt_r   <= tgt_nxt_s;
            ovl_r   <= ovl_nxt_s;
            cnt_r   <= cnt_nxt_s;
            match_r <= match_nxt_s;
            busy_r  <= (state_nxt_s == ST_ARMED);
            done_r  <= (state_nxt_s == ST_DONE);
            ready_r <= (state_nxt_s != ST_ARMED);
        end
    end

    // Next-state, shift/match evaluation and counter update.
    always_comb begin
        state_nxt_s = state_r;
        hist_nxt_s  = hist_r;
        fill_nxt_s  = fill_r;
        pat_nxt_s   = pat_r;
        tgt_nxt_s   = tgt_r;
        ovl_nxt_s   = ovl_r;
        cnt_nxt_s   = cnt_r;
        match_nxt_s = 1'b0;

        // Match is judged on the post-shift history, so the completing bit counts at once.
        shift_s    = {hist_r[PAT_W-2:0], bus.in_bit};
        fill_inc_s = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_ONE);
        cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        hit_s      = (fill_inc_s == FILL_FULL) && (shift_s == pat_r);

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.cfg_valid) begin
                    pat_nxt_s   = bus.cfg_pattern;
                    tgt_nxt_s   = bus.cfg_target;
                    ovl_nxt_s   = bus.cfg_overlap;
                    cnt_nxt_s   = CNT_ZERO;
                    hist_nxt_s  = {PAT_W{1'b0}};
                    fill_nxt_s  = FILL_ZERO;
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ARMED: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.in_valid) begin
                    hist_nxt_s = shift_s;
                    fill_nxt_s = fill_inc_s;
                    if (hit_s) begin
                        match_nxt_s = 1'b1;
                        cnt_nxt_s   = cnt_inc_s;
                        if (!ovl_r) begin
                            fill_nxt_s = FILL_ZERO;
                        end else begin
                            fill_nxt_s = fill_inc_s;
                        end
                        if ((tgt_r != CNT_ZERO) && (cnt_inc_s == tgt_r)) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        match_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign bus.cfg_ready = ready_r;
    assign bus.match     = match_r;
    assign bus.match_cnt = cnt_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
